// File: rtl/conv_writeback_if.sv
// FRAM write-port bundle between the writeback stage and the feature RAM.
//   fram_wr_en    : write request (driven by writeback)
//   fram_wr_addr  : word address of the write
//   fram_wr_data  : word to write
//   fram_wr_ready : FRAM accepts the presented write this cycle
// Modports: master = writeback side, slave = FRAM side.
interface conv_writeback_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FRAM_AW = 32
);
  logic               fram_wr_en;
  logic [FRAM_AW-1:0] fram_wr_addr;
  logic [DATA_W-1:0]  fram_wr_data;
  logic               fram_wr_ready;

  modport master (
    output fram_wr_en,
    output fram_wr_addr,
    output fram_wr_data,
    input  fram_wr_ready
  );

  modport slave (
    input  fram_wr_en,
    input  fram_wr_addr,
    input  fram_wr_data,
    output fram_wr_ready
  );
endinterface

// File: rtl/conv_writeback.sv
// Convolution writeback stage: captures one bank of PE results on out_en and
// serialises the valid lanes into consecutive FRAM word writes.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   inst_start       : layer start; loads output_baseaddr, clears wb_count
//   output_baseaddr  : first output word address of the layer
//   out_en, pe_data  : per-lane result valid and packed lane results
//   flush            : end-of-layer marker from the decoder
//   wb_busy          : capture buffer occupied; decoder must hold out_en low
//   fram             : FRAM write port (master side of conv_writeback_if)
//   wb_done          : one-cycle pulse once the flushed layer is fully written
//   wb_count         : words written since the last inst_start
//   err_overflow     : sticky, out_en arrived while busy
module conv_writeback #(
  parameter int unsigned PE_NUM  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FRAM_AW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_start,
  input  logic [FRAM_AW-1:0]       output_baseaddr,
  input  logic [PE_NUM-1:0]        out_en,
  input  logic [PE_NUM*DATA_W-1:0] pe_data,
  input  logic                     flush,
  output logic                     wb_busy,
  conv_writeback_if.master         fram,
  output logic                     wb_done,
  output logic [FRAM_AW-1:0]       wb_count,
  output logic                     err_overflow
);

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [FRAM_AW-1:0]       out_ptr_q, out_ptr_d;
  logic [FRAM_AW-1:0]       count_q, count_d;
  logic [PE_NUM*DATA_W-1:0] buf_q, buf_d;
  logic [PE_NUM-1:0]        mask_q, mask_d;
  logic                     flush_pending_q, flush_pending_d;
  logic                     err_q, err_d;
  logic                     wr_en_q, wr_en_d;
  logic [FRAM_AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;

  logic [PE_NUM-1:0]        mask_rest;
  logic [FRAM_AW-1:0]       cap_ptr;
  logic                     accept;

  // Data of the lowest-numbered lane set in mask.
  function automatic logic [DATA_W-1:0] lane_sel(input logic [PE_NUM*DATA_W-1:0] bank,
                                                 input logic [PE_NUM-1:0]        mask);
    lane_sel = '0;
    for (int i = int'(PE_NUM) - 1; i >= 0; i--) begin
      if (mask[i]) lane_sel = bank[i*DATA_W +: DATA_W];
    end
  endfunction

  // Mask with the lane currently on the bus removed.
  assign mask_rest = mask_q & (mask_q - 1'b1);
  // A capture in the inst_start cycle must use the freshly loaded base.
  assign cap_ptr   = inst_start ? output_baseaddr : out_ptr_q;
  assign accept    = wr_en_q & fram.fram_wr_ready;

  always_comb begin
    state_d         = state_q;
    out_ptr_d       = out_ptr_q;
    count_d         = count_q;
    buf_d           = buf_q;
    mask_d          = mask_q;
    flush_pending_d = flush_pending_q;
    err_d           = err_q;
    wr_en_d         = wr_en_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;

    if ((state_q != StIdle) && (out_en != '0)) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (inst_start) begin
          out_ptr_d       = output_baseaddr;
          count_d         = '0;
          flush_pending_d = 1'b0;
        end
        if (out_en != '0) begin
          buf_d     = pe_data;
          mask_d    = out_en;
          wr_en_d   = 1'b1;
          wr_addr_d = cap_ptr;
          wr_data_d = lane_sel(pe_data, out_en);
          state_d   = StDrain;
          if (flush) flush_pending_d = 1'b1;
        end else if (flush) begin
          state_d = StDone;
        end
      end
      StDrain: begin
        if (flush) flush_pending_d = 1'b1;
        if (accept) begin
          mask_d    = mask_rest;
          out_ptr_d = out_ptr_q + 1'b1;
          count_d   = count_q + 1'b1;
          if (mask_rest != '0) begin
            // Next lane goes out straight away so the bus never bubbles.
            wr_addr_d = out_ptr_q + 1'b1;
            wr_data_d = lane_sel(buf_q, mask_rest);
          end else begin
            wr_en_d = 1'b0;
            state_d = (flush_pending_q || flush) ? StDone : StIdle;
          end
        end
      end
      StDone: begin
        flush_pending_d = 1'b0;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      out_ptr_q       <= '0;
      count_q         <= '0;
      buf_q           <= '0;
      mask_q          <= '0;
      flush_pending_q <= 1'b0;
      err_q           <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      out_ptr_q       <= out_ptr_d;
      count_q         <= count_d;
      buf_q           <= buf_d;
      mask_q          <= mask_d;
      flush_pending_q <= flush_pending_d;
      err_q           <= err_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign wb_busy           = (state_q != StIdle);
  assign wb_done           = (state_q == StDone);
  assign wb_count          = count_q;
  assign err_overflow      = err_q;
  assign fram.fram_wr_en   = wr_en_q;
  assign fram.fram_wr_addr = wr_addr_q;
  assign fram.fram_wr_data = wr_data_q;

endmodule

// File: tb/tb_conv_writeback.sv
module tb_conv_writeback;
  localparam int unsigned PE_NUM  = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FRAM_AW = 32;

  logic                     clk;
  logic                     rst;
  logic                     inst_start;
  logic [FRAM_AW-1:0]       output_baseaddr;
  logic [PE_NUM-1:0]        out_en;
  logic [PE_NUM*DATA_W-1:0] pe_data;
  logic                     flush;
  logic                     wb_busy;
  logic                     wb_done;
  logic [FRAM_AW-1:0]       wb_count;
  logic                     err_overflow;

  conv_writeback_if #(.DATA_W(DATA_W), .FRAM_AW(FRAM_AW)) fram_bus ();

  conv_writeback #(.PE_NUM(PE_NUM), .DATA_W(DATA_W), .FRAM_AW(FRAM_AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_start      (inst_start),
    .output_baseaddr (output_baseaddr),
    .out_en          (out_en),
    .pe_data         (pe_data),
    .flush           (flush),
    .wb_busy         (wb_busy),
    .fram            (fram_bus),
    .wb_done         (wb_done),
    .wb_count        (wb_count),
    .err_overflow    (err_overflow)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;
  int stall_cnt = 0;
  bit bp_mode = 0;
  logic [FRAM_AW-1:0] model_ptr;
  logic [FRAM_AW+DATA_W-1:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every accepted write and checks that a
  // stalled request is held unchanged into the following cycle.
  initial begin : monitor
    logic                      prev_stall;
    logic [FRAM_AW-1:0]        prev_addr;
    logic [DATA_W-1:0]         prev_data;
    logic [FRAM_AW+DATA_W-1:0] exp;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && prev_stall) begin
        checks++;
        if (fram_bus.fram_wr_en !== 1'b1 || fram_bus.fram_wr_addr !== prev_addr ||
            fram_bus.fram_wr_data !== prev_data)
          $display("FAIL stall_hold: got en=%b %h/%h want en=1 %h/%h", fram_bus.fram_wr_en,
                   fram_bus.fram_wr_addr, fram_bus.fram_wr_data, prev_addr, prev_data);
        else passes++;
      end
      prev_stall = !rst && fram_bus.fram_wr_en === 1'b1 && fram_bus.fram_wr_ready === 1'b0;
      if (prev_stall) stall_cnt++;
      prev_addr = fram_bus.fram_wr_addr;
      prev_data = fram_bus.fram_wr_data;
      if (fram_bus.fram_wr_en === 1'b1 && fram_bus.fram_wr_ready === 1'b1) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_write: got %h/%h want no write", fram_bus.fram_wr_addr,
                   fram_bus.fram_wr_data);
        end else begin
          exp = sb_q.pop_front();
          if ({fram_bus.fram_wr_addr, fram_bus.fram_wr_data} !== exp)
            $display("FAIL write: got %h/%h want %h/%h", fram_bus.fram_wr_addr,
                     fram_bus.fram_wr_data, exp[FRAM_AW+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
          else passes++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    fram_bus.fram_wr_ready = bp_mode ? ~fram_bus.fram_wr_ready : 1'b1;
  endtask

  task automatic set_data(input logic [DATA_W-1:0] base);
    for (int i = 0; i < int'(PE_NUM); i++) pe_data[i*DATA_W +: DATA_W] = base + DATA_W'(i);
  endtask

  // Expected writes for a bank: set lanes in ascending order at consecutive words.
  task automatic push_bank(input logic [PE_NUM-1:0] en);
    for (int i = 0; i < int'(PE_NUM); i++) begin
      if (en[i]) begin
        sb_q.push_back({model_ptr, pe_data[i*DATA_W +: DATA_W]});
        model_ptr = model_ptr + 1'b1;
      end
    end
  endtask

  task automatic drive(input logic st, input logic [FRAM_AW-1:0] base,
                       input logic [PE_NUM-1:0] en, input logic fl);
    inst_start = st;
    output_baseaddr = base;
    out_en = en;
    flush = fl;
    tick();
    inst_start = 1'b0;
    out_en = '0;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (wb_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (wb_busy !== 1'b0) $display("FAIL %s_timeout: got busy=%b want 0", name, wb_busy);
    else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (wb_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", wb_busy);
    else passes++;
    checks++; if (fram_bus.fram_wr_en !== 1'b0)
      $display("FAIL rst_wr_en: got %b want 0", fram_bus.fram_wr_en); else passes++;
    checks++; if (fram_bus.fram_wr_addr !== '0)
      $display("FAIL rst_addr: got %h want 0", fram_bus.fram_wr_addr); else passes++;
    checks++; if (fram_bus.fram_wr_data !== '0)
      $display("FAIL rst_data: got %h want 0", fram_bus.fram_wr_data); else passes++;
    checks++; if (wb_done !== 1'b0) $display("FAIL rst_done: got %b want 0", wb_done);
    else passes++;
    checks++; if (wb_count !== '0) $display("FAIL rst_count: got %h want 0", wb_count);
    else passes++;
    checks++; if (err_overflow !== 1'b0) $display("FAIL rst_err: got %b want 0", err_overflow);
    else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_bank;
    int n = 0;
    set_data(32'd1);
    model_ptr = 32'h100;
    push_bank(8'hFF);
    acc_cnt = 0;
    drive(1'b1, 32'h100, 8'hFF, 1'b0);
    checks++;
    if (fram_bus.fram_wr_en !== 1'b1 || fram_bus.fram_wr_addr !== 32'h100)
      $display("FAIL full_first_latency: got en=%b addr=%h want en=1 addr=100",
               fram_bus.fram_wr_en, fram_bus.fram_wr_addr);
    else passes++;
    while (wb_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++; if (n != 8) $display("FAIL full_busy_cycles: got %0d want 8", n); else passes++;
    checks++;
    if (acc_cnt != 8 || last_acc_cyc - first_acc_cyc != 7)
      $display("FAIL full_consecutive: got %0d writes over %0d cycles want 8 over 7", acc_cnt,
               last_acc_cyc - first_acc_cyc);
    else passes++;
    checks++; if (wb_count !== 32'd8) $display("FAIL full_count: got %0d want 8", wb_count);
    else passes++;
    checks++; if (sb_q.size() != 0) $display("FAIL full_drained: got %0d left want 0", sb_q.size());
    else passes++;
  endtask

  task automatic test_sparse;
    set_data(32'h200);
    model_ptr = 32'h20;
    push_bank(8'b1010_0100);
    acc_cnt = 0;
    drive(1'b1, 32'h20, 8'b1010_0100, 1'b0);
    wait_idle(20, "sparse");
    set_data(32'h280);
    push_bank(8'h03);
    drive(1'b0, 32'h0, 8'h03, 1'b0);
    wait_idle(20, "sparse_next");
    checks++; if (acc_cnt != 5) $display("FAIL sparse_writes: got %0d want 5", acc_cnt);
    else passes++;
    checks++; if (wb_count !== 32'd5) $display("FAIL sparse_count: got %0d want 5", wb_count);
    else passes++;
  endtask

  task automatic test_backpressure;
    set_data(32'h300);
    model_ptr = 32'h30;
    push_bank(8'hFF);
    acc_cnt = 0;
    stall_cnt = 0;
    bp_mode = 1;
    drive(1'b1, 32'h30, 8'hFF, 1'b0);
    wait_idle(40, "bp");
    bp_mode = 0;
    tick();
    checks++; if (acc_cnt != 8) $display("FAIL bp_writes: got %0d want 8", acc_cnt);
    else passes++;
    checks++; if (stall_cnt < 4) $display("FAIL bp_stalls: got %0d want >=4", stall_cnt);
    else passes++;
    checks++; if (sb_q.size() != 0) $display("FAIL bp_drained: got %0d left want 0", sb_q.size());
    else passes++;
  endtask

  task automatic test_flush;
    int n = 0;
    int done_cyc;
    int acc_before;
    set_data(32'h400);
    model_ptr = 32'h300;
    push_bank(8'h0F);
    acc_cnt = 0;
    drive(1'b1, 32'h300, 8'h0F, 1'b1);
    while (wb_done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    done_cyc = cyc;
    checks++;
    if (wb_done !== 1'b1 || acc_cnt != 4 || done_cyc != last_acc_cyc + 1)
      $display("FAIL flush_done_timing: got done=%b writes=%0d at +%0d want 1, 4, +1", wb_done,
               acc_cnt, done_cyc - last_acc_cyc);
    else passes++;
    tick();
    checks++; if (wb_done !== 1'b0) $display("FAIL flush_done_width: got %b want 0", wb_done);
    else passes++;
    acc_before = acc_cnt;
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    checks++; if (wb_done !== 1'b1) $display("FAIL lone_flush_done: got %b want 1", wb_done);
    else passes++;
    tick();
    checks++;
    if (wb_done !== 1'b0 || acc_cnt != acc_before)
      $display("FAIL lone_flush_after: got done=%b writes=%0d want 0, %0d", wb_done,
               acc_cnt - acc_before, 0);
    else passes++;
  endtask

  task automatic test_overflow;
    set_data(32'h500);
    model_ptr = 32'h400;
    push_bank(8'hFF);
    acc_cnt = 0;
    drive(1'b1, 32'h400, 8'hFF, 1'b0);
    tick();
    set_data(32'hDEAD_0000);
    drive(1'b0, 32'h0, 8'h01, 1'b0);
    checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", err_overflow);
    else passes++;
    wait_idle(30, "ovf");
    checks++;
    if (acc_cnt != 8 || sb_q.size() != 0)
      $display("FAIL ovf_bank_intact: got %0d writes %0d left want 8, 0", acc_cnt, sb_q.size());
    else passes++;
    drive(1'b1, 32'h500, 8'h00, 1'b0);
    checks++; if (err_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", err_overflow);
    else passes++;
    checks++; if (wb_count !== '0) $display("FAIL start_clears_count: got %0d want 0", wb_count);
    else passes++;
  endtask

  task automatic test_wrap_and_reset;
    int left;
    set_data(32'h600);
    model_ptr = 32'hFFFF_FFFE;
    push_bank(8'h07);
    acc_cnt = 0;
    drive(1'b1, 32'hFFFF_FFFE, 8'h07, 1'b0);
    wait_idle(20, "wrap");
    checks++;
    if (acc_cnt != 3 || wb_count !== 32'd3)
      $display("FAIL wrap_writes: got %0d/%0d want 3/3", acc_cnt, wb_count);
    else passes++;
    set_data(32'h700);
    model_ptr = 32'h600;
    push_bank(8'hFF);
    acc_cnt = 0;
    drive(1'b1, 32'h600, 8'hFF, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (fram_bus.fram_wr_en !== 1'b0 || fram_bus.fram_wr_addr !== '0 ||
        fram_bus.fram_wr_data !== '0 || wb_busy !== 1'b0 || wb_done !== 1'b0 ||
        wb_count !== '0 || err_overflow !== 1'b0)
      $display("FAIL rst_mid_drain: got en=%b a=%h d=%h busy=%b done=%b cnt=%h err=%b want 0s",
               fram_bus.fram_wr_en, fram_bus.fram_wr_addr, fram_bus.fram_wr_data, wb_busy,
               wb_done, wb_count, err_overflow);
    else passes++;
    left = sb_q.size();
    checks++;
    if (acc_cnt < 1 || acc_cnt > 4 || left != 8 - acc_cnt)
      $display("FAIL rst_partial: got %0d writes %0d left want 1..4 and 8 total", acc_cnt, left);
    else passes++;
    sb_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fram_bus.fram_wr_en !== 1'b0)
        $display("FAIL post_rst_quiet: got en=%b want 0 (cycle %0d)", fram_bus.fram_wr_en, i);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_start = 1'b0;
    output_baseaddr = '0;
    out_en = '0;
    pe_data = '0;
    flush = 1'b0;
    fram_bus.fram_wr_ready = 1'b1;
    test_reset();
    test_full_bank();
    test_sparse();
    test_backpressure();
    test_flush();
    test_overflow();
    test_wrap_and_reset();
    repeat (2) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
